// File: rtl/synth_pkg.sv
// Shared definitions for the shift-add sample denormalizing multiplier.
package synth_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int SCALE_W_DEF  = 18;
  localparam int FRAC_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sequential_multiplier.sv
// Fixed-latency shift-add multiplier: product_out = (sample_in*scale) >> FRAC_W,
// one multiplier bit per cycle, done pulses once per completed operation.
module sequential_multiplier
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SCALE_W  = SCALE_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_now,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SCALE_W-1:0]  scale,
  output logic [SCALE_W-1:0]  product_out,
  output logic                done,
  output logic                busy
);

  localparam int ACC_W = SAMPLE_W + SCALE_W;
  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam int IDX_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] mplier_q, mplier_d;
  logic [SCALE_W-1:0]  mcand_q, mcand_d;
  logic [SCALE_W-1:0]  product_q, product_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      MULT: begin
        if (mplier_q[count_q[IDX_W-1:0]]) begin
          acc_d = acc_q + (ACC_W'(mcand_q) << count_q);
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = acc_q[FRAC_W +: SCALE_W];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request overrides the sequencing but leaves a DONE-cycle result intact.
    if (sample_now) begin
      mplier_d = sample_in;
      mcand_d  = scale;
      acc_d    = '0;
      count_d  = '0;
      state_d  = MULT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product_out = product_q;
  assign done        = done_q;
  assign busy        = (state_q == MULT);

endmodule

// File: doc/sequential_multiplier.md
SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, meaning the normalized sample width and the iteration count.
REQ-002 SHALL have parameter SCALE_W, default 18, meaning the scale operand and product output width.
REQ-003 SHALL have parameter FRAC_W, default 8, meaning the fractional bits of sample_in, which are discarded from the product.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port sample_now, input, 1, a start request that latches the operands.
REQ-007 SHALL have port sample_in, input, SAMPLE_W, the unsigned normalized sample (0.8 fixed point).
REQ-008 SHALL have port scale, input, SCALE_W, the unsigned denormalizing factor (the divisor used upstream).
REQ-009 SHALL have port product_out, output, SCALE_W, equal to (sample_in*scale)>>FRAC_W, truncated.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking a valid new product_out.
REQ-011 SHALL have port busy, output, 1, high while in state MULT.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, MULT and DONE.
REQ-013 In any state, sample_now=1 SHALL latch sample_in into the multiplier register and scale into the multiplicand register, clear the accumulator (SAMPLE_W+SCALE_W bits) and count, and enter MULT next cycle.
REQ-014 In MULT, each cycle SHALL add multiplicand<<count to the accumulator if multiplier bit [count] is 1, then increment count.
REQ-015 After SAMPLE_W MULT cycles, the FSM SHALL enter DONE, where product_out<=acc[FRAC_W+:SCALE_W] and done=1, then return to IDLE.
REQ-016 Latency SHALL be fixed: sample_now sampled at edge k yields done high in cycle k+SAMPLE_W+1 (edge k+9 at defaults), independent of operand values.
REQ-017 product_out SHALL hold its value until the next DONE and SHALL NOT change during MULT.
REQ-018 sample_now during MULT SHALL abort the current operation and restart with new operands, with no done pulse for the aborted operation.
REQ-019 sample_now during DONE SHALL still produce that cycle's done and product update, and SHALL restart into MULT.
REQ-020 The accumulator SHALL NOT overflow, since max (2^8-1)(2^18-1) < 2^26; truncation of the low FRAC_W bits is the only rounding.
REQ-021 In IDLE, all registers SHALL hold their values, and done and busy SHALL be 0.

Reset
REQ-022 rst=1 SHALL asynchronously force state=IDLE and clear count, accumulator and operand registers, product_out=0, done=0 and busy=0.
REQ-023 Reset mid-MULT SHALL discard the operation; after release, no done pulse SHALL occur until a new sample_now.

Structure
REQ-024 SAMPLE_W, SCALE_W, FRAC_W defaults and the state enum type SHALL reside in shared package synth_pkg.
REQ-025 The design SHALL be a single module with no sub-module, since the shift-add datapath is inline.

Verification
REQ-026 sample_in=128, scale=1000, pulse sample_now -> done in cycle 9 after the request, product_out=500.
REQ-027 sample_in=255, scale=0x3FFFF -> product_out=0x3FBFF (261119), with no overflow.
REQ-028 sample_in=0, scale=12345 -> done still at cycle 9, product_out=0, busy high for exactly 8 cycles.
REQ-029 Start 128x1000, then sample_now at cycle 4 with 64x400 -> a single done 9 cycles after the second request, product_out=100.
REQ-030 Assert rst at cycle 5 of an operation -> all outputs 0 immediately, no done pulse through 20 idle cycles.
REQ-031 Round trip: divider quotient for oscillator 1000 and divisor 2000 (=128), fed here with scale=2000 -> product_out=1000.
